// File: rtl/arbitro_pkg.sv
// Shared types and defaults for the N-channel priority arbiter.
// Pure declarations: no latency, no flow control.
package arbitro_pkg;

  localparam int DEF_N_CH     = 4;
  localparam int DEF_PERF_W   = 2;
  localparam int DEF_MAX_HOLD = 16;
  localparam int MAX_CH       = 32;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  // Callers truncate the result to their own channel count.
  function automatic logic [MAX_CH-1:0] onehot(input int idx);
    return MAX_CH'(1) << idx;
  endfunction

endpackage

// File: rtl/seletor_prioridade.sv
// Combinational winner selection: highest profile among requesters, ties by rotating scan from rr_ptr.
// Zero latency; no backpressure, outputs follow inputs.
module seletor_prioridade #(
  parameter int N_CH   = 4,
  parameter int PERF_W = 2,
  parameter int ID_W   = 2
) (
  input  logic [N_CH-1:0]        req,
  input  logic [N_CH*PERF_W-1:0] perf,
  input  logic [ID_W-1:0]        rr_ptr,
  output logic [ID_W-1:0]        winner,
  output logic                   any_req,
  output logic                   tie
);

  logic [PERF_W-1:0] max_p;
  logic [N_CH-1:0]   cand;
  logic              seen;
  logic              found;
  int                idx;

  assign any_req = |req;

  always_comb begin
    max_p  = '0;
    cand   = '0;
    seen   = 1'b0;
    found  = 1'b0;
    idx    = 0;
    winner = '0;
    tie    = 1'b0;

    // Non-requesting channels never contribute to the maximum.
    for (int i = 0; i < N_CH; i++) begin
      if (req[i] && (perf[i*PERF_W +: PERF_W] > max_p)) begin
        max_p = perf[i*PERF_W +: PERF_W];
      end
    end

    for (int i = 0; i < N_CH; i++) begin
      cand[i] = req[i] && (perf[i*PERF_W +: PERF_W] == max_p);
      if (cand[i]) begin
        if (seen) tie = 1'b1;
        seen = 1'b1;
      end
    end

    for (int k = 0; k < N_CH; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && cand[idx]) begin
        winner = ID_W'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_prioridade.sv
// N-channel priority arbiter with round-robin tie break, registered one-hot grant and hold timeout.
// Request-to-grant 1 cycle; grant held until release/drop/timeout, then a 1-cycle gap.
module arbitro_prioridade
  import arbitro_pkg::*;
#(
  parameter  int N_CH     = DEF_N_CH,
  parameter  int PERF_W   = DEF_PERF_W,
  parameter  int MAX_HOLD = DEF_MAX_HOLD,
  localparam int ID_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH-1:0]        req,
  input  logic [N_CH*PERF_W-1:0] perf,
  // "release" is a reserved word in SystemVerilog, hence the longer name.
  input  logic                   release_req,
  output logic [N_CH-1:0]        grant,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy,
  output logic                   tie,
  output logic                   timeout
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  state_t            state, state_d;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_d;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
  logic [N_CH-1:0]   grant_d;
  logic [ID_W-1:0]   grant_id_d;
  logic              busy_d, tie_d, timeout_d;

  logic [ID_W-1:0]   sel_winner;
  logic              sel_any, sel_tie;
  logic              ex_rel, ex_drop, ex_hold;

  seletor_prioridade #(
    .N_CH   (N_CH),
    .PERF_W (PERF_W),
    .ID_W   (ID_W)
  ) u_sel (
    .req     (req),
    .perf    (perf),
    .rr_ptr  (rr_ptr),
    .winner  (sel_winner),
    .any_req (sel_any),
    .tie     (sel_tie)
  );

  assign ex_rel  = release_req;
  assign ex_drop = !req[grant_id];
  assign ex_hold = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    state_d    = state;
    rr_ptr_d   = rr_ptr;
    hold_cnt_d = hold_cnt;
    grant_d    = grant;
    grant_id_d = grant_id;
    busy_d     = busy;
    tie_d      = tie;
    timeout_d  = 1'b0;

    unique case (state)
      IDLE: begin
        if (sel_any) begin
          state_d    = GRANT;
          grant_d    = N_CH'(onehot(int'(sel_winner)));
          grant_id_d = sel_winner;
          busy_d     = 1'b1;
          tie_d      = sel_tie;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        hold_cnt_d = hold_cnt + HOLD_W'(1);
        if (ex_rel || ex_drop || ex_hold) begin
          state_d   = GAP;
          grant_d   = '0;
          busy_d    = 1'b0;
          tie_d     = 1'b0;
          // Timeout is reported only when nothing else would have ended the grant.
          timeout_d = ex_hold && !ex_rel && !ex_drop;
          rr_ptr_d  = (grant_id == ID_W'(N_CH - 1)) ? '0 : grant_id + ID_W'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      tie      <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_d;
      rr_ptr   <= rr_ptr_d;
      hold_cnt <= hold_cnt_d;
      grant    <= grant_d;
      grant_id <= grant_id_d;
      busy     <= busy_d;
      tie      <= tie_d;
      timeout  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_arbitro_prioridade.sv
// Self-checking bench for arbitro_prioridade (N_CH=4, PERF_W=2, MAX_HOLD=16).
module tb_arbitro_prioridade;

  typedef struct {
    logic [3:0] req;
    logic [7:0] perf;
    logic       rel;
    logic [3:0] g;
    logic [1:0] id;
    logic       busy;
    logic       tie;
    logic       to;
  } vec_t;

  typedef struct {
    int   due;
    int   idx;
    vec_t v;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] perf = '0;
  logic       release_req = 1'b0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy, tie, timeout;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int n_drv = 0;
  sb_t  sb[$];
  vec_t tbl[$];

  arbitro_prioridade #(
    .N_CH     (4),
    .PERF_W   (2),
    .MAX_HOLD (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .perf        (perf),
    .release_req (release_req),
    .grant       (grant),
    .grant_id    (grant_id),
    .busy        (busy),
    .tie         (tie),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] rq, input logic [7:0] pf, input logic rl,
                              input logic [3:0] g, input logic [1:0] id, input logic b,
                              input logic t, input logic to);
    vec_t v;
    v.req = rq; v.perf = pf; v.rel = rl;
    v.g = g; v.id = id; v.busy = b; v.tie = t; v.to = to;
    return v;
  endfunction

  // Pops every expectation that falls due at this negedge and compares it.
  task automatic service();
    sb_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("due", e.idx, 32'(e.due), 32'(cyc));
      chk("grant", e.idx, 32'(grant), 32'(e.v.g));
      chk("grant_id", e.idx, 32'(grant_id), 32'(e.v.id));
      chk("busy", e.idx, 32'(busy), 32'(e.v.busy));
      chk("tie", e.idx, 32'(tie), 32'(e.v.tie));
      chk("timeout", e.idx, 32'(timeout), 32'(e.v.to));
    end
  endtask

  // Applies one cycle of inputs; the expectation is for the outputs after the next rising edge.
  task automatic drive(input vec_t v);
    sb_t e;
    @(negedge clk);
    service();
    req = v.req;
    perf = v.perf;
    release_req = v.rel;
    e.due = cyc + 1;
    e.idx = n_drv;
    e.v = v;
    sb.push_back(e);
    n_drv++;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() > 0; i++) begin
      @(negedge clk);
      service();
    end
    chk("sb_drain", n_drv, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int prev;
    int w;

    // Distinct profiles ch3=1 ch2=3 ch1=0 ch0=2: ch2 wins alone, then release, gap, idle.
    tbl.push_back(mk(4'hF, 8'h72, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(4'hF, 8'h72, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'hF, 8'h72, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0));
    // rr_ptr is now 3: a full tie starts the rotation at ch3.
    tbl.push_back(mk(4'hF, 8'hFF, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0));
    prev = 3;
    for (int k = 0; k < 5; k++) begin
      w = k % 4;
      tbl.push_back(mk(4'hF, 8'hFF, 1'b1, 4'b0000, 2'(prev), 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(4'hF, 8'hFF, 1'b0, 4'b0000, 2'(prev), 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk(4'hF, 8'hFF, 1'b0, 4'(1 << w), 2'(w), 1'b1, 1'b1, 1'b0));
      prev = w;
    end
    // Grant on ch0 ends by request drop; rr_ptr becomes 1.
    tbl.push_back(mk(4'h0, 8'hFF, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'h0, 8'hFF, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'h0, 8'h00, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
    // Idle ch1 has the highest profile but is not requesting: ch2 wins alone.
    tbl.push_back(mk(4'b0101, 8'h2D, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(4'b0101, 8'h2D, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'b0000, 8'h2D, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0));
    // Tie between ch3 and ch0 with rr_ptr=3: ch3 wins.
    tbl.push_back(mk(4'b1001, 8'h8E, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(4'b1001, 8'h8E, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'b0000, 8'h8E, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0));
    // Legacy two-channel case: equal profiles, rr_ptr=0, ch0 wins.
    tbl.push_back(mk(4'b0011, 8'h05, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(4'b0011, 8'h05, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(4'b0000, 8'h05, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));

    #1 reset = 1'b1;
    #2;
    chk("rst_grant", 0, 32'(grant), 32'd0);
    chk("rst_grant_id", 0, 32'(grant_id), 32'd0);
    chk("rst_busy", 0, 32'(busy), 32'd0);
    chk("rst_tie", 0, 32'(tie), 32'd0);
    chk("rst_timeout", 0, 32'(timeout), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) drive(tbl[i]);

    // Hold timeout on ch1 (rr_ptr=1): exactly 16 grant cycles, then a timeout pulse.
    for (int i = 0; i < 16; i++)
      drive(mk(4'b0010, 8'h00, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0));
    drive(mk(4'b0010, 8'h00, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b1));
    drive(mk(4'b0010, 8'h00, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0));
    drive(mk(4'b0010, 8'h00, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0));
    drive(mk(4'b0010, 8'h00, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0));
    drive(mk(4'b0000, 8'h00, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0));

    // No preemption: ch1 arrives with a higher profile, ch0 keeps the grant until it drops.
    drive(mk(4'b0001, 8'h01, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0));
    drive(mk(4'b0011, 8'h0D, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0));
    drive(mk(4'b0011, 8'h0D, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0));
    drive(mk(4'b0010, 8'h0D, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
    drive(mk(4'b0010, 8'h0D, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
    drive(mk(4'b0010, 8'h0D, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0));
    drive(mk(4'b0010, 8'h0D, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0));
    drive(mk(4'b0000, 8'h0D, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0));

    // rr_ptr=2 and a full tie grants ch2; then reset lands between clock edges.
    drive(mk(4'hF, 8'hFF, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0));
    drain();
    #2;
    reset = 1'b1;
    req = '0;
    #1;
    chk("async_grant", n_drv, 32'(grant), 32'd0);
    chk("async_busy", n_drv, 32'(busy), 32'd0);
    chk("async_tie", n_drv, 32'(tie), 32'd0);
    chk("async_grant_id", n_drv, 32'(grant_id), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    // rr_ptr cleared by reset: the same full tie now goes to ch0.
    drive(mk(4'hF, 8'hFF, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0));
    drive(mk(4'hF, 8'hFF, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
    drive(mk(4'h0, 8'hFF, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
